// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads programMem, and hands the
// registered instruction word and its PC to decode over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int unsigned                DATAWIDTH_BUS = 32,
   parameter logic [DATAWIDTH_BUS-1:0]   RESET_PC      = 32'h0000_0800,
   parameter int unsigned                PC_STEP       = 4
) (
   input  logic                     CLOCK_50,
   input  logic                     RESET_InHigh,
   input  logic                     FETCH_Enable,
   input  logic                     FETCH_Ready,
   input  logic                     FETCH_BranchTaken,
   input  logic [DATAWIDTH_BUS-1:0] FETCH_BranchTarget,
   input  logic [DATAWIDTH_BUS-1:0] FETCH_BusDatos,
   output logic                     FETCH_RD,
   output logic                     FETCH_WR,
   output logic [DATAWIDTH_BUS-1:0] FETCH_BusDirecciones,
   output logic [DATAWIDTH_BUS-1:0] FETCH_IR,
   output logic [DATAWIDTH_BUS-1:0] FETCH_IRPC,
   output logic                     FETCH_Valid,
   output logic                     FETCH_Halted
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CAPTURE,
      VALID,
      HALT
   } state_t;

   localparam logic [DATAWIDTH_BUS-1:0] STEP       = DATAWIDTH_BUS'(PC_STEP);
   localparam logic [DATAWIDTH_BUS-1:0] ALIGN_MASK = ~DATAWIDTH_BUS'(3);

   state_t                   state_q, state_d;
   logic [DATAWIDTH_BUS-1:0] pc_q, pc_d;
   logic [DATAWIDTH_BUS-1:0] ir_q, ir_d;
   logic [DATAWIDTH_BUS-1:0] irpc_q, irpc_d;

   always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
      if (RESET_InHigh) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         irpc_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         irpc_q  <= irpc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      irpc_d  = irpc_q;
      unique case (state_q)
         IDLE: begin
            if (FETCH_Enable) state_d = ADDR;
         end
         ADDR: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            ir_d    = FETCH_BusDatos;
            irpc_d  = pc_q;
            // An all-zero word marks end of program and is never handed to decode.
            state_d = (FETCH_BusDatos == '0) ? HALT : VALID;
         end
         VALID: begin
            if (FETCH_Ready) begin
               pc_d    = FETCH_BranchTaken ? (FETCH_BranchTarget & ALIGN_MASK)
                                           : pc_q + STEP;
               state_d = FETCH_Enable ? ADDR : IDLE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign FETCH_RD             = (state_q == ADDR) || (state_q == CAPTURE);
   assign FETCH_WR             = 1'b0;
   assign FETCH_BusDirecciones = pc_q;
   assign FETCH_IR             = ir_q;
   assign FETCH_IRPC           = irpc_q;
   assign FETCH_Valid          = (state_q == VALID);
   assign FETCH_Halted         = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle vector table plus a handoff
// scoreboard fed by a behavioural programMem.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, rdy = 1'b0, br = 1'b0;
   logic [31:0] tgt = '0;
   logic [31:0] bus;
   logic        rd, wr, valid, halted;
   logic [31:0] addr, ir, irpc;

   int          nvec = 0;
   int          errs = 0;
   logic [63:0] sb[$];
   logic [31:0] prog[16];

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .DATAWIDTH_BUS(32),
      .RESET_PC     (32'h0000_0800),
      .PC_STEP      (4)
   ) dut (
      .CLOCK_50            (clk),
      .RESET_InHigh        (rst),
      .FETCH_Enable        (en),
      .FETCH_Ready         (rdy),
      .FETCH_BranchTaken   (br),
      .FETCH_BranchTarget  (tgt),
      .FETCH_BusDatos      (bus),
      .FETCH_RD            (rd),
      .FETCH_WR            (wr),
      .FETCH_BusDirecciones(addr),
      .FETCH_IR            (ir),
      .FETCH_IRPC          (irpc),
      .FETCH_Valid         (valid),
      .FETCH_Halted        (halted)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[1:0] == 2'b00 && a >= 32'h800 && a < 32'h840)
         return prog[int'((a - 32'h800) >> 2)];
      return a ^ 32'h5A5A_5A5A;
   endfunction

   assign bus = rd ? mem_word(addr) : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] a);
      sb.push_back({mem_word(a), a});
   endtask

   // Every handoff edge must match the oldest expected {IR, IRPC}.
   always @(negedge clk) begin
      if (!rst && valid && rdy) begin
         nvec++;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL handoff: unexpected IR %h IRPC %h expected none", ir, irpc);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            if ({ir, irpc} !== e) begin
               errs++;
               $display("FAIL handoff: got IR %h IRPC %h expected IR %h IRPC %h",
                        ir, irpc, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk_reset(input string nm);
      chk({nm, "_rd"}, {31'd0, rd}, 32'd0);
      chk({nm, "_wr"}, {31'd0, wr}, 32'd0);
      chk({nm, "_addr"}, addr, 32'h800);
      chk({nm, "_ir"}, ir, 32'd0);
      chk({nm, "_irpc"}, irpc, 32'd0);
      chk({nm, "_vh"}, {30'd0, valid, halted}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      en = 1'b0; rdy = 1'b0; br = 1'b0; tgt = '0;
      #1 chk_reset("reset");
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_valid_at(input logic [31:0] a);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (valid && irpc == a) return;
      end
      chk("wait_valid_timeout", irpc, a);
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk(nm, sb.size(), 32'd0);
   endtask

   typedef struct {
      logic        en, rdy, br;
      logic [31:0] tgt;
      logic        rd, valid, halt;
      logic [31:0] addr, ir, irpc;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) prog[i] = 32'h0100_0000 * i + 32'h11;
      prog[0]  = 32'h8280_2001;
      prog[1]  = 32'h8480_2001;
      prog[7]  = 32'h0CBF_FFFC;
      prog[14] = 32'h0000_0000;

      // en rdy br tgt | rd valid halt addr ir irpc
      vecs[0]  = '{1, 1, 0, 0,       0, 0, 0, 32'h800, 32'h0,         32'h0};
      vecs[1]  = '{1, 1, 0, 0,       1, 0, 0, 32'h800, 32'h0,         32'h0};
      vecs[2]  = '{1, 1, 0, 0,       1, 0, 0, 32'h800, 32'h0,         32'h0};
      vecs[3]  = '{1, 1, 0, 0,       0, 1, 0, 32'h800, 32'h8280_2001, 32'h800};
      vecs[4]  = '{1, 0, 0, 0,       1, 0, 0, 32'h804, 32'h8280_2001, 32'h800};
      vecs[5]  = '{1, 0, 0, 0,       1, 0, 0, 32'h804, 32'h8280_2001, 32'h800};
      vecs[6]  = '{1, 0, 0, 0,       0, 1, 0, 32'h804, 32'h8480_2001, 32'h804};
      vecs[7]  = '{1, 0, 1, 32'h900, 0, 1, 0, 32'h804, 32'h8480_2001, 32'h804};
      vecs[8]  = '{1, 0, 1, 32'h900, 0, 1, 0, 32'h804, 32'h8480_2001, 32'h804};
      vecs[9]  = '{1, 0, 1, 32'h900, 0, 1, 0, 32'h804, 32'h8480_2001, 32'h804};
      vecs[10] = '{1, 0, 0, 0,       0, 1, 0, 32'h804, 32'h8480_2001, 32'h804};
      vecs[11] = '{1, 1, 0, 0,       0, 1, 0, 32'h804, 32'h8480_2001, 32'h804};
      vecs[12] = '{1, 1, 0, 0,       1, 0, 0, 32'h808, 32'h8480_2001, 32'h804};

      // First fetches, latency, and a 5-cycle decode stall with ignored branch.
      do_reset();
      push_exp(32'h800);
      push_exp(32'h804);
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         en = vecs[i].en; rdy = vecs[i].rdy; br = vecs[i].br; tgt = vecs[i].tgt;
         @(negedge clk);
         nvec++;
         if ({rd, wr, valid, halted, addr, ir, irpc} !==
             {vecs[i].rd, 1'b0, vecs[i].valid, vecs[i].halt, vecs[i].addr, vecs[i].ir, vecs[i].irpc}) begin
            errs++;
            $display("FAIL vec%0d: got rd%b wr%b v%b h%b addr %h ir %h irpc %h expected rd%b wr0 v%b h%b addr %h ir %h irpc %h",
                     i, rd, wr, valid, halted, addr, ir, irpc, vecs[i].rd, vecs[i].valid,
                     vecs[i].halt, vecs[i].addr, vecs[i].ir, vecs[i].irpc);
         end
      end
      chk("table_drain", sb.size(), 32'd0);

      // Branches: misaligned target 0x81E, then 0x833 from 0x81C; run to halt.
      do_reset();
      for (int a = 32'h800; a <= 32'h818; a += 4) push_exp(a);
      push_exp(32'h81C);
      push_exp(32'h830);
      push_exp(32'h834);
      en = 1'b1; rdy = 1'b1;
      wait_valid_at(32'h818);
      br = 1'b1; tgt = 32'h81E;
      @(posedge clk); #1 br = 1'b0;
      wait_valid_at(32'h81C);
      br = 1'b1; tgt = 32'h833;
      @(posedge clk); #1 br = 1'b0;
      wait_drain("branch_drain");
      for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
      chk("branch_halt", {31'd0, halted}, 32'd1);

      // Free run to end-of-program, then halt must be sticky.
      do_reset();
      for (int a = 32'h800; a <= 32'h834; a += 4) push_exp(a);
      en = 1'b1; rdy = 1'b1;
      for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_drain", sb.size(), 32'd0);
      chk("halt_irpc", irpc, 32'h838);
      chk("halt_ir", ir, 32'h0);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         en = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("halt_sticky", {rd, valid, halted, addr[28:0]}, {3'b001, 29'h838});
      end

      // Asynchronous reset during CAPTURE at 0x810.
      do_reset();
      for (int a = 32'h800; a <= 32'h80C; a += 4) push_exp(a);
      en = 1'b1; rdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd && addr == 32'h810) break;
      end
      @(negedge clk);
      chk("capture_rd", {31'd0, rd}, 32'd1);
      #2 rst = 1'b1;
      #1 chk_reset("async");
      chk("async_drain", sb.size(), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      push_exp(32'h800);
      wait_drain("restart_drain");

      // PC wrap at 0xFFFFFFFC, pause on handoff, branch with Enable=0.
      do_reset();
      push_exp(32'h800);
      push_exp(32'hFFFF_FFFC);
      en = 1'b1; rdy = 1'b1;
      wait_valid_at(32'h800);
      br = 1'b1; tgt = 32'hFFFF_FFFC;
      @(posedge clk); #1 br = 1'b0;
      wait_valid_at(32'hFFFF_FFFC);
      en = 1'b0;
      @(posedge clk);
      repeat (3) @(negedge clk);
      chk("wrap_addr", addr, 32'h0);
      chk("wrap_idle", {30'd0, rd, valid}, 32'd0);
      push_exp(32'h0);
      en = 1'b1;
      wait_valid_at(32'h0);
      br = 1'b1; tgt = 32'h82E; en = 1'b0;
      @(posedge clk); #1 br = 1'b0;
      repeat (2) @(negedge clk);
      chk("redir_idle_addr", addr, 32'h82C);
      chk("redir_idle", {30'd0, rd, valid}, 32'd0);
      push_exp(32'h82C);
      en = 1'b1;
      wait_drain("resume_drain");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of programMem. Holds the program counter and drives programMem's RD/WR/address inputs. Captures the returned BusDatos word into an instruction register. Hands each instruction, with its PC, to the decode stage over a valid/ready handshake. Stops permanently when an all-zero instruction word (end-of-program) is fetched.

Parameters:
DATAWIDTH_BUS, 32, width of PC, address bus and instruction word
RESET_PC, 32'h0000_0800, PC value after reset (first program word)
PC_STEP, 4, byte increment between sequential instructions

Ports:
CLOCK_50  input  1  system clock, rising edge
RESET_InHigh  input  1  asynchronous reset, active-high
FETCH_Enable  input  1  level; 1 = run fetch loop, 0 = pause after current handoff
FETCH_Ready  input  1  decode stage accepts instruction this cycle
FETCH_BranchTaken  input  1  redirect PC; sampled only on a handoff cycle
FETCH_BranchTarget  input  DATAWIDTH_BUS  redirect byte address
FETCH_BusDatos  input  DATAWIDTH_BUS  instruction word from programMem BusDatos
FETCH_RD  output  1  to programMem RD
FETCH_WR  output  1  to programMem WR, constant 0
FETCH_BusDirecciones  output  DATAWIDTH_BUS  to programMem BusDirecciones, always equal to PC
FETCH_IR  output  DATAWIDTH_BUS  captured instruction
FETCH_IRPC  output  DATAWIDTH_BUS  address FETCH_IR was fetched from
FETCH_Valid  output  1  FETCH_IR/FETCH_IRPC valid for decode
FETCH_Halted  output  1  end-of-program reached

Behaviour:
- Reset (async, immediate, also mid-fetch):
  - PC=RESET_PC, state=IDLE.
  - FETCH_RD=0, FETCH_WR=0, FETCH_IR=0, FETCH_IRPC=0, FETCH_Valid=0, FETCH_Halted=0.
- FSM states: IDLE, ADDR, CAPTURE, VALID, HALT.
- IDLE: RD=0. Goes to ADDR on the next edge if FETCH_Enable=1.
- ADDR: RD=1, address=PC (setup cycle for programMem). Always goes to CAPTURE.
- CAPTURE: RD=1, address=PC unchanged.
  - On the edge: IR<=FETCH_BusDatos, IRPC<=PC.
  - If FETCH_BusDatos==0: go to HALT. Valid stays 0 and the zero word is not handed off.
  - Otherwise: go to VALID.
- Fetch latency: ADDR entry to Valid=1 is 2 cycles.
- VALID: RD=0, Valid=1; IR/IRPC held stable until handoff.
  - Handoff = Valid && FETCH_Ready, evaluated at the edge.
  - On handoff, Valid drops next cycle.
  - PC <= BranchTaken ? {BranchTarget[W-1:2],2'b00} : PC+PC_STEP.
  - Next state = FETCH_Enable ? ADDR : IDLE.
  - No handoff: stay in VALID; BranchTaken is ignored.
- HALT: RD=0, Valid=0, Halted=1. Sticky; exits only via reset. PC holds the halting address.
- Arithmetic:
  - PC+PC_STEP is modulo 2^DATAWIDTH_BUS (0xFFFFFFFC -> 0x00000000).
  - Branch target low 2 bits are forced to 0.
- FETCH_Enable:
  - Dropped in ADDR/CAPTURE: the current fetch completes and is handed off, then the FSM enters IDLE.
  - Raised in IDLE: resumes at the current PC.
- Simultaneous BranchTaken and Enable=0 on handoff: PC is redirected, then the FSM enters IDLE.
- FETCH_BusDirecciones = PC in every state, including IDLE/HALT. programMem reads only while RD=1.
- No combinational path from FETCH_BusDatos to any output; IR is registered.

Test Plan:
- Reset, Enable=1, Ready=1 -> address 0x800 with RD=1 for 2 cycles. Valid=1 on 3rd cycle with IR=0x82802001, IRPC=0x800. Next fetch at 0x804 returns IR=0x84802001.
- Ready=0 for 5 cycles during VALID -> Valid, IR and IRPC constant. RD=0 and PC=0x804 throughout. Ready=1 -> single handoff, then fetch from 0x808.
- At handoff of IRPC=0x818, BranchTaken=1, Target=0x81E -> next fetch address 0x81C, IR=0x0CBFFFFC, IRPC=0x81C.
- Free run from reset with no branches -> 14 instructions handed off, 0x800..0x834. Fetch at 0x838 returns 0 -> Halted=1, Valid=0, never asserts again. Enable/Ready toggling has no effect.
- Assert RESET_InHigh asynchronously during CAPTURE at 0x810 -> all outputs go to reset values immediately. After release, fetch restarts at 0x800.
- Force PC to 0xFFFFFFFC via branch target, then handoff without branch -> next address 0x00000000. Enable=0 at handoff -> FSM idles with RD=0.
